// File: rtl/sm_serial_adder_if.sv
// Handshake and operand/result bundle for the bit-serial sign-magnitude adder.
// The requester (master) drives start and operands; the adder (slave) returns
// status and the registered result.
interface sm_serial_adder_if #(
    parameter int N = 8
);
    logic         i_start;
    logic [N-1:0] i_a;
    logic [N-1:0] i_b;
    logic         o_busy;
    logic         o_done;
    logic [N-1:0] o_out;
    logic         o_carry;

    modport master (
        output i_start,
        output i_a,
        output i_b,
        input  o_busy,
        input  o_done,
        input  o_out,
        input  o_carry
    );

    modport slave (
        input  i_start,
        input  i_a,
        input  i_b,
        output o_busy,
        output o_done,
        output o_out,
        output o_carry
    );
endinterface

// File: rtl/sm_serial_adder.sv
// Bit-serial sign-magnitude adder. The magnitudes are combined one bit per
// clock, LSB first: a full add when the signs match and a full subtract
// |A| - |B| when they differ. A final borrow means |A| < |B|, so the
// magnitude register is serially two's-complemented before the result is
// published. A zero magnitude is always reported with a positive sign.
module sm_serial_adder #(
    parameter int N = 8
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    sm_serial_adder_if.slave    bus
);

    localparam int M  = N - 1;                 // magnitude width
    localparam int CW = (N > 3) ? $clog2(N - 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 2);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        NEG  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t        state;
    state_t        state_next;

    // Operand magnitudes, shifted right so the active bit is always bit 0.
    logic [M-1:0]  a_sh;
    logic [M-1:0]  b_sh;
    // Result magnitude; new bits enter at the MSB so bit k lands at position k.
    logic [M-1:0]  res_sh;
    logic [CW-1:0] cnt;
    // Carry for same-sign adds, borrow for different-sign subtracts.
    logic          cb;
    logic          op_sub;
    logic          sign_a;
    logic          sign_b;
    // Set once the first 1 has been copied during two's-complement.
    logic          seen_one;

    logic          out_done;
    logic [N-1:0]  out_val;
    logic          out_carry;

    // Decoded controls from the output process.
    logic          busy;
    logic          accept;
    logic          add_step;
    logic          neg_step;
    logic          publish;

    logic          a_bit;
    logic          b_bit;
    logic          res_bit;
    logic          cb_next;
    logic          neg_bit;
    logic          last_bit;
    logic          res_sign;

    assign a_bit    = a_sh[0];
    assign b_bit    = b_sh[0];
    assign last_bit = (cnt == CNT_LAST);

    // Sum and difference share the same bit equation; only the carry/borrow
    // propagation differs between the two operations.
    assign res_bit = a_bit ^ b_bit ^ cb;
    assign cb_next = op_sub ? ((~a_bit & b_bit) | (~(a_bit ^ b_bit) & cb))
                            : ((a_bit & b_bit) | (cb & (a_bit ^ b_bit)));

    // Two's-complement: copy up to and including the first 1, invert after.
    assign neg_bit = seen_one ? ~res_sh[0] : res_sh[0];

    // A final borrow means |B| won, so B's sign applies; zero is always +.
    assign res_sign = (|res_sh) & ((op_sub && cb) ? sign_b : sign_a);

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (bus.i_start) begin
                    state_next = ADD;
                end
            end
            ADD: begin
                if (last_bit) begin
                    state_next = (op_sub && cb_next) ? NEG : DONE;
                end
            end
            NEG: begin
                if (last_bit) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State-decoded controls.
    always_comb begin
        busy     = 1'b0;
        accept   = 1'b0;
        add_step = 1'b0;
        neg_step = 1'b0;
        publish  = 1'b0;
        case (state)
            IDLE: accept   = bus.i_start;
            ADD: begin
                busy     = 1'b1;
                add_step = 1'b1;
            end
            NEG: begin
                busy     = 1'b1;
                neg_step = 1'b1;
            end
            DONE: publish  = 1'b1;
            default: begin
                busy     = 1'b0;
            end
        endcase
    end

    // Serial datapath: capture on accept, one magnitude bit per ADD/NEG cycle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            a_sh     <= '0;
            b_sh     <= '0;
            res_sh   <= '0;
            cnt      <= '0;
            cb       <= 1'b0;
            op_sub   <= 1'b0;
            sign_a   <= 1'b0;
            sign_b   <= 1'b0;
            seen_one <= 1'b0;
        end else if (accept) begin
            a_sh     <= bus.i_a[M-1:0];
            b_sh     <= bus.i_b[M-1:0];
            res_sh   <= '0;
            cnt      <= '0;
            cb       <= 1'b0;
            op_sub   <= bus.i_a[N-1] ^ bus.i_b[N-1];
            sign_a   <= bus.i_a[N-1];
            sign_b   <= bus.i_b[N-1];
            seen_one <= 1'b0;
        end else if (add_step) begin
            a_sh   <= {1'b0, a_sh[M-1:1]};
            b_sh   <= {1'b0, b_sh[M-1:1]};
            res_sh <= {res_bit, res_sh[M-1:1]};
            cb     <= cb_next;
            cnt    <= last_bit ? '0 : cnt + CW'(1);
        end else if (neg_step) begin
            res_sh   <= {neg_bit, res_sh[M-1:1]};
            seen_one <= seen_one | res_sh[0];
            cnt      <= last_bit ? '0 : cnt + CW'(1);
        end
    end

    // Result registers: published from DONE and held until the next DONE.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            out_done  <= 1'b0;
            out_val   <= '0;
            out_carry <= 1'b0;
        end else begin
            out_done <= publish;
            if (publish) begin
                out_val   <= {res_sign, res_sh};
                out_carry <= ~op_sub & cb;
            end
        end
    end

    assign bus.o_busy  = busy;
    assign bus.o_done  = out_done;
    assign bus.o_out   = out_val;
    assign bus.o_carry = out_carry;

endmodule

// File: tb/tb_sm_serial_adder.sv
// Bench for sm_serial_adder (N = 8): table-driven vectors and random operands
// feed a scoreboard queue that is checked whenever o_done pulses, plus
// hand-written sequences for busy-start, back-to-back and reset abort.
module tb_sm_serial_adder;

    localparam int N = 8;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    sm_serial_adder_if #(.N(N)) bus();

    sm_serial_adder #(.N(N)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] exp_out;
        logic       exp_carry;
        int         exp_lat;
    } vec_t;

    typedef struct {
        logic [7:0] exp_out;
        logic       exp_carry;
        int         exp_lat;
        int         accept_cyc;
    } sb_t;

    sb_t  sb[$];
    sb_t  ent;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   busy_cnt;
    logic prev_done = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Independent integer model of sign-magnitude addition.
    task automatic model(input logic [7:0] a, input logic [7:0] b,
                         output logic [7:0] o, output logic c, output int lat);
        int ma, mb, s, mag;
        logic sg;
        ma = int'(a[6:0]);
        mb = int'(b[6:0]);
        lat = 8;
        c = 1'b0;
        if (a[7] == b[7]) begin
            s = ma + mb;
            mag = s % 128;
            c = (s >= 128);
            sg = a[7];
        end else if (ma >= mb) begin
            mag = ma - mb;
            sg = a[7];
        end else begin
            mag = mb - ma;
            sg = b[7];
            lat = 15;
        end
        if (mag == 0) sg = 1'b0;
        o = {sg, 7'(mag)};
    endtask

    // Scoreboard: compare each o_done pulse against the oldest expectation.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && bus.o_done === 1'b1) begin
            check("done_pulse_width", {31'd0, prev_done}, 32'd0);
            if (sb.size() == 0) begin
                check("spurious_done", 32'd1, 32'd0);
            end else begin
                ent = sb.pop_front();
                check("o_out", {24'd0, bus.o_out}, {24'd0, ent.exp_out});
                check("o_carry", {31'd0, bus.o_carry}, {31'd0, ent.exp_carry});
                if (ent.exp_lat > 0)
                    check("latency", cyc - ent.accept_cyc, ent.exp_lat);
            end
        end
        prev_done = bus.o_done;
    end

    // Called at a negedge; accept happens on the next posedge.
    task automatic start_op(input logic [7:0] a, input logic [7:0] b,
                            input logic [7:0] eo, input logic ec, input int el);
        bus.i_a = a;
        bus.i_b = b;
        bus.i_start = 1'b1;
        sb.push_back('{eo, ec, el, cyc + 1});
        @(negedge clk);
        bus.i_start = 1'b0;
        busy_cnt = (bus.o_busy === 1'b1) ? 1 : 0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 60) begin
            @(negedge clk);
            n++;
            if (bus.o_busy === 1'b1) busy_cnt++;
        end
        check("drain_timeout", sb.size(), 32'd0);
        sb.delete();
        @(negedge clk);
    endtask

    vec_t tv[9];
    logic [7:0] ra, rb, mo;
    logic       mc;
    int         ml;
    int         t1, t2, n;
    logic       got;

    initial begin
        tv[0] = '{8'h05, 8'h03, 8'h08, 1'b0, 8};
        tv[1] = '{8'hE4, 8'hB2, 8'h96, 1'b1, 8};
        tv[2] = '{8'h14, 8'hB2, 8'h9E, 1'b0, 15};
        tv[3] = '{8'h87, 8'h07, 8'h00, 1'b0, 8};
        tv[4] = '{8'h80, 8'h80, 8'h00, 1'b0, 8};
        tv[5] = '{8'h7F, 8'h01, 8'h00, 1'b1, 8};
        tv[6] = '{8'hFF, 8'h7F, 8'h00, 1'b0, 8};
        tv[7] = '{8'h03, 8'h85, 8'h82, 1'b0, 15};
        tv[8] = '{8'h00, 8'h00, 8'h00, 1'b0, 8};

        rst_n = 1'b0;
        bus.i_start = 1'b0;
        bus.i_a = '0;
        bus.i_b = '0;
        #12;
        check("reset_busy", {31'd0, bus.o_busy}, 32'd0);
        check("reset_done", {31'd0, bus.o_done}, 32'd0);
        check("reset_out", {24'd0, bus.o_out}, 32'd0);
        check("reset_carry", {31'd0, bus.o_carry}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed table
        for (int i = 0; i < 9; i++) begin
            start_op(tv[i].a, tv[i].b, tv[i].exp_out, tv[i].exp_carry, tv[i].exp_lat);
            wait_drain();
            if (i == 0) check("busy_cycles", busy_cnt, 32'd7);
            if (i == 2) check("busy_cycles_neg", busy_cnt, 32'd14);
        end

        // Random operands against the model
        for (int i = 0; i < 16; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            model(ra, rb, mo, mc, ml);
            start_op(ra, rb, mo, mc, ml);
            wait_drain();
        end

        // Start while busy is ignored
        start_op(8'h05, 8'h03, 8'h08, 1'b0, 8);
        repeat (2) @(negedge clk);
        bus.i_a = 8'h7F;
        bus.i_b = 8'h7F;
        bus.i_start = 1'b1;
        @(negedge clk);
        bus.i_start = 1'b0;
        wait_drain();
        repeat (20) @(negedge clk);
        check("busy_start_idle", {31'd0, bus.o_busy}, 32'd0);

        // Back-to-back with start held high
        bus.i_a = 8'h05;
        bus.i_b = 8'h03;
        bus.i_start = 1'b1;
        sb.push_back('{8'h08, 1'b0, 8, cyc + 1});
        got = 1'b0;
        n = 0;
        t1 = 0;
        while (!got && n < 40) begin
            @(negedge clk);
            n++;
            if (bus.o_done === 1'b1) begin
                got = 1'b1;
                t1 = cyc;
                sb.push_back('{8'h08, 1'b0, 8, cyc + 1});
            end
        end
        check("b2b_first_done", {31'd0, got}, 32'd1);
        @(negedge clk);
        bus.i_start = 1'b0;
        got = 1'b0;
        n = 0;
        t2 = 0;
        while (!got && n < 40) begin
            @(negedge clk);
            n++;
            if (bus.o_done === 1'b1) begin
                got = 1'b1;
                t2 = cyc;
            end
        end
        check("b2b_second_done", {31'd0, got}, 32'd1);
        check("b2b_gap", t2 - t1, 32'd9);
        wait_drain();

        // Reset during NEG aborts asynchronously
        start_op(8'h14, 8'hB2, 8'h9E, 1'b0, 15);
        repeat (9) @(negedge clk);
        check("pre_reset_busy", {31'd0, bus.o_busy}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_busy", {31'd0, bus.o_busy}, 32'd0);
        check("abort_done", {31'd0, bus.o_done}, 32'd0);
        check("abort_out", {24'd0, bus.o_out}, 32'd0);
        check("abort_carry", {31'd0, bus.o_carry}, 32'd0);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (25) @(negedge clk);
        check("abort_idle_busy", {31'd0, bus.o_busy}, 32'd0);
        check("abort_idle_out", {24'd0, bus.o_out}, 32'd0);
        start_op(8'h01, 8'h01, 8'h02, 1'b0, 8);
        wait_drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
